// File: rtl/lane_align_pkg.sv
// lane_align_pkg: state encoding and default timing constants shared by
// lane_align_ctrl and anything that observes its debug state.
package lane_align_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETTLE  = 3'd1,
    S_CHECK   = 3'd2,
    S_SLIP    = 3'd3,
    S_NEXT    = 3'd4,
    S_DONE    = 3'd5,
    S_FAIL    = 3'd6,
    S_MONITOR = 3'd7
  } state_e;

  localparam int DEF_SETTLE_CYCLES = 4;
  localparam int DEF_CHECK_CYCLES  = 16;
  localparam int DEF_MAX_SLIPS     = 1;

endpackage

// File: rtl/lane_align_ctrl.sv
// lane_align_ctrl: walks the lanes one at a time, checks the training pattern and
// requests bitslips. Macro LANE_ALIGN_MONITOR_EN adds a post-lock drift monitor.
module lane_align_ctrl
  import lane_align_pkg::*;
#(
  parameter int   LANES         = 8,
  parameter logic EXP_RISE      = 1'b1,
  parameter logic EXP_FALL      = 1'b0,
  parameter int   SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int   CHECK_CYCLES  = DEF_CHECK_CYCLES,
  parameter int   MAX_SLIPS     = DEF_MAX_SLIPS
) (
  input  logic             dco_clk,
  input  logic             rst_n,
  input  logic             align_start,
  input  logic [LANES-1:0] lane_rise,
  input  logic [LANES-1:0] lane_fall,
  output logic [LANES-1:0] bitslip_pulse,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [LANES-1:0] lane_locked,
  output logic [LANES-1:0] lane_error,
  output logic [LANES-1:0] lane_drift,
  output state_e           state_dbg
);

  localparam int LIW = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int SW  = $clog2(SETTLE_CYCLES + 1);
  localparam int CW  = $clog2(CHECK_CYCLES + 1);
  localparam int PW  = (MAX_SLIPS > 0) ? $clog2(MAX_SLIPS + 1) : 1;

  localparam logic [LIW-1:0] LAST_LANE   = LIW'(LANES - 1);
  localparam logic [SW-1:0]  SETTLE_LOAD = SW'(SETTLE_CYCLES);
  localparam logic [CW-1:0]  CHECK_LAST  = CW'(CHECK_CYCLES - 1);
  localparam logic [PW-1:0]  SLIP_LIMIT  = PW'(MAX_SLIPS);

  state_e           state_q, state_d;
  logic [LIW-1:0]   lane_idx_q, lane_idx_d;
  logic [SW-1:0]    settle_cnt_q, settle_cnt_d;
  logic [CW-1:0]    check_cnt_q, check_cnt_d;
  logic [PW-1:0]    slip_cnt_q, slip_cnt_d;
  logic [LANES-1:0] locked_q, locked_d, error_q, error_d, pulse_q, pulse_d;
  logic             done_q, done_d, fail_q, fail_d, busy_q, busy_d;
  logic             sample_ok;

  assign sample_ok = (lane_rise[lane_idx_q] == EXP_RISE) &&
                     (lane_fall[lane_idx_q] == EXP_FALL);

`ifdef LANE_ALIGN_MONITOR_EN
  logic [LANES-1:0] drift_q, drift_d, mismatch;
  assign mismatch   = (lane_rise ^ {LANES{EXP_RISE}}) | (lane_fall ^ {LANES{EXP_FALL}});
  assign lane_drift = drift_q;
`else
  assign lane_drift = '0;
`endif

  always_comb begin
    state_d      = state_q;
    lane_idx_d   = lane_idx_q;
    settle_cnt_d = settle_cnt_q;
    check_cnt_d  = check_cnt_q;
    slip_cnt_d   = slip_cnt_q;
    locked_d     = locked_q;
    error_d      = error_q;
    done_d       = done_q;
    fail_d       = fail_q;
    pulse_d      = '0;
`ifdef LANE_ALIGN_MONITOR_EN
    drift_d      = drift_q;
`endif
    case (state_q)
      S_SETTLE: begin
        settle_cnt_d = settle_cnt_q - SW'(1);
        if (settle_cnt_q <= SW'(1)) begin
          state_d     = S_CHECK;
          check_cnt_d = '0;
        end
      end
      S_CHECK: begin
        if (sample_ok) begin
          check_cnt_d = check_cnt_q + CW'(1);
          if (check_cnt_q == CHECK_LAST) begin
            locked_d[lane_idx_q] = 1'b1;
            state_d              = S_NEXT;
          end
        end else if (slip_cnt_q < SLIP_LIMIT) begin
          // Pulse is registered on entry so it is high exactly during SLIP.
          pulse_d[lane_idx_q] = 1'b1;
          state_d             = S_SLIP;
        end else begin
          error_d[lane_idx_q] = 1'b1;
          state_d             = S_NEXT;
        end
      end
      S_SLIP: begin
        slip_cnt_d   = slip_cnt_q + PW'(1);
        settle_cnt_d = SETTLE_LOAD;
        state_d      = S_SETTLE;
      end
      S_NEXT: begin
        if (lane_idx_q == LAST_LANE) begin
          if (error_q == '0) begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = S_FAIL;
            fail_d  = 1'b1;
          end
        end else begin
          lane_idx_d   = lane_idx_q + LIW'(1);
          slip_cnt_d   = '0;
          settle_cnt_d = SETTLE_LOAD;
          state_d      = S_SETTLE;
        end
      end
      default: begin
        // IDLE, DONE, FAIL and MONITOR all accept a new pass.
        if (align_start) begin
          locked_d     = '0;
          error_d      = '0;
          done_d       = 1'b0;
          fail_d       = 1'b0;
          lane_idx_d   = '0;
          slip_cnt_d   = '0;
          settle_cnt_d = SETTLE_LOAD;
          state_d      = S_SETTLE;
`ifdef LANE_ALIGN_MONITOR_EN
          drift_d      = '0;
        end else if (state_q == S_DONE || state_q == S_FAIL) begin
          state_d = S_MONITOR;
        end else if (state_q == S_MONITOR) begin
          drift_d = drift_q | (locked_q & mismatch);
`endif
        end
      end
    endcase
    busy_d = (state_d == S_SETTLE) || (state_d == S_CHECK) ||
             (state_d == S_SLIP)   || (state_d == S_NEXT);
  end

  always_ff @(posedge dco_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      lane_idx_q   <= '0;
      settle_cnt_q <= '0;
      check_cnt_q  <= '0;
      slip_cnt_q   <= '0;
      locked_q     <= '0;
      error_q      <= '0;
      pulse_q      <= '0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
      busy_q       <= 1'b0;
`ifdef LANE_ALIGN_MONITOR_EN
      drift_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      lane_idx_q   <= lane_idx_d;
      settle_cnt_q <= settle_cnt_d;
      check_cnt_q  <= check_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      locked_q     <= locked_d;
      error_q      <= error_d;
      pulse_q      <= pulse_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
      busy_q       <= busy_d;
`ifdef LANE_ALIGN_MONITOR_EN
      drift_q      <= drift_d;
`endif
    end
  end

  assign bitslip_pulse = pulse_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign fail          = fail_q;
  assign lane_locked   = locked_q;
  assign lane_error    = error_q;
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_lane_align_ctrl.sv
// tb_lane_align_ctrl: drives lane patterns through a simple slip-stage model and
// checks pass timing, slip requests and per-lane status against a lane-outcome model.
module tb_lane_align_ctrl;
  import lane_align_pkg::*;

  localparam int LANES  = 8;
  localparam int SETTLE = 4;
  localparam int CHECK  = 16;
  localparam int MAXS   = 1;
  localparam int LIMIT  = 2000;
  localparam int T_CLEAN = 0, T_SWAP = 1, T_STUCK = 2;
`ifdef LANE_ALIGN_MONITOR_EN
  localparam logic [LANES-1:0] EXP_DRIFT = 8'h02;
`else
  localparam logic [LANES-1:0] EXP_DRIFT = 8'h00;
`endif

  logic             dco_clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             align_start = 1'b0;
  logic [LANES-1:0] lane_rise, lane_fall;
  logic [LANES-1:0] bitslip_pulse, lane_locked, lane_error, lane_drift;
  logic             busy, done, fail;
  state_e           state_dbg;

  int               lane_type[LANES];
  logic             stuck_val[LANES];
  logic [LANES-1:0] slipped, glitch;
  logic [LANES-1:0] exp_q[$];
  logic [LANES-1:0] exp_locked, exp_error;
  int               exp_cycles, got_cyc;
  int               total = 0;
  int               bad = 0;

  lane_align_ctrl #(
    .LANES(LANES), .EXP_RISE(1'b1), .EXP_FALL(1'b0),
    .SETTLE_CYCLES(SETTLE), .CHECK_CYCLES(CHECK), .MAX_SLIPS(MAXS)
  ) dut (
    .dco_clk(dco_clk), .rst_n(rst_n), .align_start(align_start),
    .lane_rise(lane_rise), .lane_fall(lane_fall),
    .bitslip_pulse(bitslip_pulse), .busy(busy), .done(done), .fail(fail),
    .lane_locked(lane_locked), .lane_error(lane_error), .lane_drift(lane_drift),
    .state_dbg(state_dbg)
  );

  // clock
  always #5 dco_clk = ~dco_clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Slip-stage model: a swapped lane reads 0/1 until one half-bit slip, a slip toggles phase.
  task automatic drive_lanes();
    for (int i = 0; i < LANES; i++) begin
      case (lane_type[i])
        T_SWAP:  begin lane_rise[i] = slipped[i];  lane_fall[i] = ~slipped[i]; end
        T_STUCK: begin lane_rise[i] = stuck_val[i]; lane_fall[i] = stuck_val[i]; end
        default: begin lane_rise[i] = 1'b1;        lane_fall[i] = 1'b0;        end
      endcase
      lane_rise[i] = lane_rise[i] ^ glitch[i];
    end
  endtask

  // One clock; outputs observed at the falling edge, inputs updated there too.
  task automatic step();
    @(posedge dco_clk);
    @(negedge dco_clk);
    if (bitslip_pulse != '0) begin
      if (exp_q.size() == 0) check_val("slip_unexpected", bitslip_pulse, '0);
      else                   check_val("slip_pulse", bitslip_pulse, exp_q.pop_front());
      slipped = slipped ^ bitslip_pulse;
    end
    drive_lanes();
  endtask

  // Lane outcome model: each check attempt costs SETTLE plus the samples it consumes,
  // each slip one cycle, and finishing a lane one cycle.
  task automatic build_model();
    exp_cycles = 0;
    exp_locked = '0;
    exp_error  = '0;
    exp_q.delete();
    for (int i = 0; i < LANES; i++) begin
      case (lane_type[i])
        T_SWAP: begin
          exp_cycles += (SETTLE + 1) + 1 + (SETTLE + CHECK) + 1;
          exp_q.push_back(LANES'(1) << i);
          exp_locked[i] = 1'b1;
        end
        T_STUCK: begin
          for (int s = 0; s < MAXS; s++) begin
            exp_cycles += (SETTLE + 1) + 1;
            exp_q.push_back(LANES'(1) << i);
          end
          exp_cycles += (SETTLE + 1) + 1;
          exp_error[i] = 1'b1;
        end
        default: begin
          exp_cycles += SETTLE + CHECK + 1;
          exp_locked[i] = 1'b1;
        end
      endcase
    end
  endtask

  task automatic run_pass(input string tag, input int poke);
    build_model();
    slipped = '0;
    glitch  = '0;
    drive_lanes();
    align_start = 1'b1;
    step();
    align_start = 1'b0;
    check_val({tag, "_busy"}, busy, 1'b1);
    got_cyc = -1;
    for (int c = 1; c <= LIMIT; c++) begin
      if (c == poke) align_start = 1'b1;
      step();
      align_start = 1'b0;
      if (done || fail) begin
        got_cyc = c;
        break;
      end
    end
    check_val({tag, "_cycles"}, got_cyc, exp_cycles);
    check_val({tag, "_done"}, done, (exp_error == '0));
    check_val({tag, "_fail"}, fail, (exp_error != '0));
    check_val({tag, "_locked"}, lane_locked, exp_locked);
    check_val({tag, "_error"}, lane_error, exp_error);
    check_val({tag, "_idle"}, busy, 1'b0);
    check_val({tag, "_slips_left"}, exp_q.size(), 0);
  endtask

  task automatic set_all_clean();
    for (int i = 0; i < LANES; i++) begin
      lane_type[i] = T_CLEAN;
      stuck_val[i] = 1'b0;
    end
  endtask

  initial begin
    set_all_clean();
    slipped = '0;
    glitch  = '0;
    drive_lanes();
    repeat (3) @(negedge dco_clk);
    check_val("rst_locked", lane_locked, '0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_done", done, 1'b0);
    check_val("rst_fail", fail, 1'b0);
    check_val("rst_pulse", bitslip_pulse, '0);
    check_val("rst_state", state_dbg, S_IDLE);
    rst_n = 1'b1;
    step();

    // all clean, with a stray start mid-pass
    run_pass("clean", 30);

    set_all_clean();
    lane_type[3] = T_SWAP;
    run_pass("swap3", 100);

    set_all_clean();
    lane_type[5] = T_STUCK;
    run_pass("stuck5", 0);

    // drift on lane 1 after a good pass
    set_all_clean();
    run_pass("pre_mon", 0);
    step();
    step();
    glitch[1] = 1'b1;
    drive_lanes();
    step();
    glitch = '0;
    drive_lanes();
    repeat (3) step();
    check_val("mon_drift", lane_drift, EXP_DRIFT);
    check_val("mon_done", done, 1'b1);
    repeat (4) step();
    check_val("mon_drift_sticky", lane_drift, EXP_DRIFT);

    // reset during lane 2 check
    set_all_clean();
    build_model();
    align_start = 1'b1;
    step();
    align_start = 1'b0;
    repeat (50) step();
    check_val("mid_locked", lane_locked, 8'h03);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_locked", lane_locked, '0);
    check_val("mid_rst_busy", busy, 1'b0);
    check_val("mid_rst_pulse", bitslip_pulse, '0);
    check_val("mid_rst_state", state_dbg, S_IDLE);
    repeat (2) step();
    rst_n = 1'b1;
    step();
    run_pass("after_rst", 0);

    // randomized lane mixes
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < LANES; i++) begin
        if ($urandom_range(0, 5) < 4) lane_type[i] = T_CLEAN;
        else lane_type[i] = ($urandom_range(0, 1) != 0) ? T_SWAP : T_STUCK;
        stuck_val[i] = 1'($urandom_range(0, 1));
      end
      run_pass($sformatf("rand%0d", p), int'($urandom_range(0, 90)));
      check_val($sformatf("rand%0d_drift", p), lane_drift, '0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lane_align_ctrl.md
# lane_align_ctrl

Training-pattern alignment controller for the ADC front-end lanes. Sits downstream of the per-lane half-bit slip stage. It checks each lane's corrected rise/fall pair against the ADC's alternating training pattern, one lane at a time. It issues single-cycle bitslip requests to that stage and reports per-lane lock/error status to the frame aligner and the control registers.

## Interface
- LANES, 8: number of data lanes (≥1)
- EXP_RISE, 1'b1: expected bit on the rise phase when aligned
- EXP_FALL, 1'b0: expected bit on the fall phase when aligned
- SETTLE_CYCLES, 4: wait after start or slip before checking (≥2)
- CHECK_CYCLES, 16: consecutive matching samples required for lock (≥1)
- MAX_SLIPS, 1: slips tried per lane before declaring error
---
- dco_clk  in  1  clock; all logic on posedge
- rst_n  in  1  reset; asynchronous, active-low
- align_start  in  1  pulse; starts a full alignment pass
- lane_rise  in  LANES  corrected rise data from slip stage
- lane_fall  in  LANES  corrected fall data from slip stage (negedge-registered; sampled here on posedge)
- bitslip_pulse  out  LANES  one-hot, one-cycle slip request to slip stage
- busy  out  1  pass in progress
- done  out  1  pass finished, all lanes locked (level until next start)
- fail  out  1  pass finished, ≥1 lane errored (level until next start)
- lane_locked  out  LANES  per-lane lock status
- lane_error  out  LANES  per-lane alignment failure
- lane_drift  out  LANES  sticky post-lock mismatch (see Configuration)

## Operation
- States: IDLE, SETTLE, CHECK, SLIP, NEXT, DONE, FAIL (MONITOR when macro set).
- IDLE/DONE/FAIL + align_start: clear lane_locked, lane_error, lane_drift, done, fail; lane_idx=0, slip_cnt=0, settle_cnt=SETTLE_CYCLES; → SETTLE.
- align_start in any other state: ignored.
- SETTLE: decrement settle_cnt; on last cycle → CHECK with check_cnt=0.
- CHECK: sample {lane_rise[lane_idx], lane_fall[lane_idx]}.
  - Match {EXP_RISE,EXP_FALL}: check_cnt++. On the CHECK_CYCLES-th consecutive match: set lane_locked[lane_idx], → NEXT.
  - Mismatch with slip_cnt<MAX_SLIPS: → SLIP.
  - Mismatch with slip_cnt==MAX_SLIPS: set lane_error[lane_idx], → NEXT.
- SLIP: bitslip_pulse[lane_idx]=1 for this cycle only; slip_cnt++; reload settle_cnt; → SETTLE.
- NEXT: if lane_idx==LANES-1 → DONE when lane_error==0, else → FAIL. Otherwise lane_idx++, slip_cnt=0, reload settle_cnt; → SETTLE.
- busy=1 in SETTLE/CHECK/SLIP/NEXT.
- Counter widths: $clog2(max+1), minimum 1 bit. lane_idx never exceeds LANES-1.

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- Reset mid-pass: returns to IDLE immediately; no bitslip_pulse emitted after rst_n falls.
- All outputs are registered.
- Clean lane: SETTLE_CYCLES + CHECK_CYCLES + 1 cycles. Defaults: 21 cycles per lane; done rises 168 cycles after the edge that samples align_start (8 clean lanes).
- Each slip whose mismatch occurs on the first CHECK sample adds SETTLE_CYCLES+2 cycles (6 at defaults).
- A mismatch on CHECK sample k adds k-1 further cycles.
- SETTLE_CYCLES≥2 covers the slip stage's offset-update plus output-register latency.

## Configuration
- LANE_ALIGN_MONITOR_EN defined:
  - DONE/FAIL are followed next cycle by MONITOR, which reports done/fail identically.
  - In MONITOR, every cycle, any locked lane whose sample mismatches sets lane_drift for that lane (sticky).
  - align_start from MONITOR behaves as from DONE.
- Undefined: no MONITOR state; lane_drift tied to 0; port retained.

## Structure
- Package lane_align_pkg: state enum typedef and default SETTLE/CHECK constants.
- No sub-module; single FSM with counters.

## Test plan
- All lanes driven 1/0 pattern, start pulse → no bitslip_pulse; done=1 at +168 cycles; lane_locked=8'hFF.
- Lane 3 driven 0/1 → single bitslip_pulse=8'h08 during lane 3; model slips it; done=1 at +174; lane_locked=8'hFF.
- Lane 5 stuck 0/0 → one slip on lane 5, then lane_error=8'h20, fail=1, done=0, lane_locked=8'hDF.
- rst_n asserted during lane 2 CHECK → all outputs 0 next edge; a new start restarts from lane 0.
- align_start repeated while busy → ignored; pass timing unchanged.
- LANE_ALIGN_MONITOR_EN: after done, flip lane 1 for one cycle → lane_drift=8'h02 sticky; done stays 1.
